multicycle_core: RTL

MULTICYCLE_CORE -- requirements
Module: multicycle_core

---
 rtl/core_pkg.sv | 134 +++++++++++++
 rtl/regfile.sv | 34 +++
 rtl/multicycle_core.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset core.
// Decoding and immediate formation live here so the FSM stays readable.
package core_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_PASS
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LUI,
      CLS_JAL,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_ILLEGAL
   } cls_t;

   typedef struct packed {
      cls_t    cls;
      alu_op_t alu_op;
      imm_t    imm_type;
      logic    use_imm;
      logic    br_ne;
   } decode_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;

   // Anything not matched exactly falls through as CLS_ILLEGAL.
   function automatic decode_t decode_instr(input logic [31:0] instr);
      decode_t d;
      d = '{cls: CLS_ILLEGAL, alu_op: ALU_ADD, imm_type: IMM_NONE,
            use_imm: 1'b0, br_ne: 1'b0};
      case (instr[6:0])
         OPC_OP: begin
            if (instr[14:12] == F3_ADD && instr[31:25] == F7_ADD) begin
               d.cls = CLS_ALU;
            end else if (instr[14:12] == F3_ADD && instr[31:25] == F7_SUB) begin
               d.cls    = CLS_ALU;
               d.alu_op = ALU_SUB;
            end
         end
         OPC_OP_IMM: begin
            if (instr[14:12] == F3_ADD) begin
               d.cls      = CLS_ALU;
               d.imm_type = IMM_I;
               d.use_imm  = 1'b1;
            end
         end
         OPC_LUI: begin
            d.cls      = CLS_LUI;
            d.alu_op   = ALU_PASS;
            d.imm_type = IMM_U;
            d.use_imm  = 1'b1;
         end
         OPC_LOAD: begin
            if (instr[14:12] == F3_LW) begin
               d.cls      = CLS_LOAD;
               d.imm_type = IMM_I;
               d.use_imm  = 1'b1;
            end
         end
         OPC_STORE: begin
            if (instr[14:12] == F3_SW) begin
               d.cls      = CLS_STORE;
               d.imm_type = IMM_S;
               d.use_imm  = 1'b1;
            end
         end
         OPC_BRANCH: begin
            if (instr[14:12] == F3_BEQ || instr[14:12] == F3_BNE) begin
               d.cls      = CLS_BRANCH;
               d.imm_type = IMM_B;
               d.br_ne    = (instr[14:12] == F3_BNE);
            end
         end
         OPC_JAL: begin
            d.cls      = CLS_JAL;
            d.imm_type = IMM_J;
         end
         default: ;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] make_imm(input logic [31:0] instr, input imm_t kind);
      logic [31:0] imm;
      case (kind)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'd0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// x0 is hardwired to zero and x10 is exposed directly as a0.
module regfile
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   output logic [31:0] a0
);

   logic [31:0] regs [32];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= 32'd0;
         end
      end else if (we && waddr != 5'd0) begin
         regs[waddr] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
   assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
   assign a0     = regs[10];

endmodule

// File: rtl/multicycle_core.sv
// Unified-memory multicycle core for a small RV32I subset.
// One memory port serves both instruction fetch and LW/SW data accesses.
module multicycle_core
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          ADDR_W   = 32
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] a0,
   output logic        trap
);

   localparam logic [31:0] PC_MASK =
      (ADDR_W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << ADDR_W) - 64'd1);

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic [31:0] imm_reg;
   logic [31:0] alu_out;
   logic [31:0] mdr;

   decode_t     dec;
   logic [31:0] imm_val;
   logic [31:0] rdata1;
   logic [31:0] rdata2;
   logic        rf_we;
   logic [31:0] rf_wdata;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic [31:0] pc_plus4;
   logic [31:0] pc_target;
   logic        br_taken;
   logic [31:0] addr_sel;

   assign dec     = decode_instr(ir);
   assign imm_val = make_imm(ir, dec.imm_type);

   regfile u_regfile (
      .clk    (clk),
      .rst    (rst),
      .raddr1 (ir[19:15]),
      .raddr2 (ir[24:20]),
      .rdata1 (rdata1),
      .rdata2 (rdata2),
      .we     (rf_we),
      .waddr  (ir[11:7]),
      .wdata  (rf_wdata),
      .a0     (a0)
   );

   assign alu_b     = dec.use_imm ? imm_reg : b_reg;
   assign pc_plus4  = (pc + 32'd4) & PC_MASK;
   assign pc_target = (pc + imm_reg) & PC_MASK;
   assign br_taken  = dec.br_ne ? (a_reg != b_reg) : (a_reg == b_reg);

   always_comb begin
      alu_result = 32'd0;
      case (dec.alu_op)
         ALU_ADD:  alu_result = a_reg + alu_b;
         ALU_SUB:  alu_result = a_reg - alu_b;
         ALU_PASS: alu_result = alu_b;
         default:  alu_result = 32'd0;
      endcase
   end

   assign rf_we    = (state == S_WB);
   assign rf_wdata = (dec.cls == CLS_LOAD) ? mdr : alu_out;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:  if (mem_ready) state_next = S_DECODE;
         S_DECODE: state_next = (dec.cls == CLS_ILLEGAL) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            case (dec.cls)
               CLS_LOAD, CLS_STORE: state_next = S_MEM;
               CLS_BRANCH:          state_next = S_FETCH;
               default:             state_next = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               state_next = (dec.cls == CLS_LOAD) ? S_WB : S_FETCH;
            end
         end
         S_WB:     state_next = S_FETCH;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_FETCH;
      endcase
   end

   // Requests are gated by rst so they drop the instant reset asserts, even mid-access.
   always_comb begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      addr_sel = pc;
      case (state)
         S_FETCH: mem_req = rst;
         S_MEM: begin
            mem_req  = rst;
            mem_we   = rst && (dec.cls == CLS_STORE);
            addr_sel = alu_out;
         end
         default: ;
      endcase
   end

   assign mem_addr  = addr_sel & PC_MASK & 32'hFFFF_FFFC;
   assign mem_wdata = b_reg;
   assign trap      = (state == S_TRAP);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc      <= RESET_PC & PC_MASK;
         ir      <= 32'd0;
         a_reg   <= 32'd0;
         b_reg   <= 32'd0;
         imm_reg <= 32'd0;
         alu_out <= 32'd0;
         mdr     <= 32'd0;
      end else begin
         case (state)
            S_FETCH: begin
               if (mem_ready) ir <= mem_rdata;
            end
            S_DECODE: begin
               a_reg   <= rdata1;
               b_reg   <= rdata2;
               imm_reg <= imm_val;
            end
            S_EXEC: begin
               case (dec.cls)
                  CLS_BRANCH: pc      <= br_taken ? pc_target : pc_plus4;
                  CLS_JAL:    alu_out <= pc_plus4;
                  default:    alu_out <= alu_result;
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (dec.cls == CLS_LOAD) begin
                     mdr <= mem_rdata;
                  end else begin
                     pc <= pc_plus4;
                  end
               end
            end
            S_WB: begin
               pc <= (dec.cls == CLS_JAL) ? pc_target : pc_plus4;
            end
            default: ;
         endcase
      end
   end

endmodule
